// File: rtl/spi_status_tx.sv
// SPI-slave MISO side of the host link (mode 0, MSB first).
// Returns {status_code, result_field} once per SPI byte slot.
`timescale 1ns/1ps
module spi_status_tx #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [3:0]  STATUS_RESULT = 4'b1000,
    parameter logic [7:0]  DISABLED_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       miso_oe,
    input  logic [3:0] status_code,
    input  logic [3:0] result_out,
    input  logic       tx_enable,
    output logic       byte_sent,
    output logic       frame_abort,
    output logic       tx_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   sclk_q;
    logic                   cs_q;
    logic                   sclk_rise_p;
    logic                   sclk_fall_p;
    logic                   cs_rise_p;
    logic                   cs_fall_p;

    logic [7:0] shreg, shreg_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic       reload, reload_d;
    logic       seen_rise, seen_rise_d;
    logic       miso_d;
    logic       oe_d;
    logic       busy_d;
    logic       sent_d;
    logic       abort_d;
    logic [7:0] load_byte;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // CS chain resets low so a CS held low across reset never looks like a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync   <= '0;
            cs_sync     <= '0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b0;
            sclk_rise_p <= 1'b0;
            sclk_fall_p <= 1'b0;
            cs_rise_p   <= 1'b0;
            cs_fall_p   <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_q      <= sclk_s;
            cs_q        <= cs_s;
            sclk_rise_p <= sclk_s & ~sclk_q;
            sclk_fall_p <= ~sclk_s & sclk_q;
            cs_rise_p   <= cs_s & ~cs_q;
            cs_fall_p   <= ~cs_s & cs_q;
        end
    end

    always_comb begin
        load_byte = DISABLED_BYTE;
        if (tx_enable) begin
            load_byte = {status_code,
                         (status_code == STATUS_RESULT) ? result_out : 4'h0};
        end
    end

    always_comb begin
        state_d     = state;
        shreg_d     = shreg;
        bit_cnt_d   = bit_cnt;
        reload_d    = reload;
        seen_rise_d = seen_rise;
        miso_d      = spi_miso;
        oe_d        = miso_oe;
        busy_d      = tx_busy;
        sent_d      = 1'b0;
        abort_d     = 1'b0;
        unique case (state)
            S_IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                busy_d = 1'b0;
                if (cs_fall_p) begin
                    state_d     = S_LOAD;
                    shreg_d     = load_byte;
                    miso_d      = load_byte[7];
                    oe_d        = 1'b1;
                    busy_d      = 1'b1;
                    bit_cnt_d   = 3'd0;
                    reload_d    = 1'b0;
                    seen_rise_d = 1'b0;
                end
            end
            S_LOAD, S_SHIFT: begin
                state_d = S_SHIFT;
                if (cs_rise_p) begin
                    state_d   = S_IDLE;
                    miso_d    = 1'b0;
                    oe_d      = 1'b0;
                    busy_d    = 1'b0;
                    abort_d   = (bit_cnt != 3'd0);
                    bit_cnt_d = 3'd0;
                    reload_d  = 1'b0;
                end else if (sclk_rise_p) begin
                    bit_cnt_d   = bit_cnt + 3'd1;
                    seen_rise_d = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        sent_d   = 1'b1;
                        reload_d = 1'b1;
                    end
                end else if (sclk_fall_p) begin
                    // A fall with no rise since the last load is a leading idle edge.
                    if (reload) begin
                        shreg_d     = load_byte;
                        miso_d      = load_byte[7];
                        reload_d    = 1'b0;
                        seen_rise_d = 1'b0;
                    end else if (seen_rise) begin
                        shreg_d = {shreg[6:0], 1'b0};
                        miso_d  = shreg[6];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shreg       <= 8'h00;
            bit_cnt     <= 3'd0;
            reload      <= 1'b0;
            seen_rise   <= 1'b0;
            spi_miso    <= 1'b0;
            miso_oe     <= 1'b0;
            tx_busy     <= 1'b0;
            byte_sent   <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_d;
            shreg       <= shreg_d;
            bit_cnt     <= bit_cnt_d;
            reload      <= reload_d;
            seen_rise   <= seen_rise_d;
            spi_miso    <= miso_d;
            miso_oe     <= oe_d;
            tx_busy     <= busy_d;
            byte_sent   <= sent_d;
            frame_abort <= abort_d;
        end
    end

endmodule
